// File: rtl/ram_seq.sv
// ram_seq: transaction sequencer for the MAR/MDR SRAM register block.
// Turns whole read / write / byte-masked write requests into the per-cycle
// reg_sel / reg_load_ub / reg_load_lb / read / write command sequence and
// returns read data on a response port.
// Optional feature macro: RAM_SEQ_VERIFY_EN (read-back verify after writes).
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. req_ready is high only in IDLE; the requester holds
// req_valid and the request fields until accepted. rsp_valid stays high,
// with rsp_rdata/rsp_err stable, until the edge where rsp_ready is high.
module ram_seq #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] reg_d,
    input  logic [15:0] reg_q,
    output logic        reg_sel,
    output logic        reg_load_ub,
    output logic        reg_load_lb,
    output logic        read,
    output logic        write,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_MAR = 4'd1,
        LOAD_MDR = 4'd2,
        READ     = 4'd3,
        CAPTURE  = 4'd4,
        WRITE    = 4'd5,
`ifdef RAM_SEQ_VERIFY_EN
        VREAD    = 4'd7,
        VCAPTURE = 4'd8,
`endif
        RESP     = 4'd6
    } state_t;

    localparam logic [7:0] RD_LAST = 8'(READ_CYCLES - 1);
    localparam logic [7:0] WR_LAST = 8'(WRITE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_write;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_be;
    logic [15:0] r_rdata;
    logic        w_rd_last;
    logic        w_wr_last;
    logic        w_accept;

    assign w_rd_last = (r_cnt == RD_LAST);
    assign w_wr_last = (r_cnt == WR_LAST);
    assign w_accept  = req_valid && (r_state == IDLE);
    assign rsp_rdata = r_rdata;
    assign dbg_state = r_state;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobe-length counter: restarts whenever the state changes, so it is
    // zero on the first cycle of READ / WRITE / VREAD.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= 8'(r_cnt + 8'd1);
        end
    end

    // Latch the request on accept; capture read data at the end of a read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_addr  <= 16'd0;
            r_wdata <= 16'd0;
            r_be    <= 2'b00;
            r_rdata <= 16'd0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_rdata <= 16'd0;
        end else if (r_state == CAPTURE) begin
            r_rdata <= reg_q;
        end
    end

`ifdef RAM_SEQ_VERIFY_EN
    logic [15:0] r_pre;
    logic        r_err;
    logic [15:0] w_expect;

    // Expected word after the write: new bytes where enabled, old elsewhere.
    assign w_expect = {r_be[1] ? r_wdata[15:8] : r_pre[15:8],
                       r_be[0] ? r_wdata[7:0]  : r_pre[7:0]};
    assign rsp_err  = r_err;

    // During LOAD_MDR the MDR still holds the pre-read word; keep it, then
    // compare the verify read-back against the expected merge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= 16'd0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == LOAD_MDR) begin
            r_pre <= reg_q;
        end else if (r_state == VCAPTURE) begin
            r_err <= (reg_q != w_expect);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Next state and Moore command decode from state + latched request.
    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        reg_d       = 16'd0;
        reg_sel     = 1'b0;
        reg_load_ub = 1'b0;
        reg_load_lb = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = LOAD_MAR;
            end
            LOAD_MAR: begin
                reg_sel     = 1'b1;
                reg_load_ub = 1'b1;
                reg_load_lb = 1'b1;
                reg_d       = r_addr;
                if (!r_write)             w_next = READ;
                else if (r_be == 2'b00)   w_next = RESP;
                else if (r_be == 2'b11)   w_next = LOAD_MDR;
                else                      w_next = READ;  // partial: read-modify-write
            end
            LOAD_MDR: begin
                reg_load_ub = r_be[1];
                reg_load_lb = r_be[0];
                reg_d       = r_wdata;
                w_next      = WRITE;
            end
            READ: begin
                read = 1'b1;
                if (w_rd_last) w_next = r_write ? LOAD_MDR : CAPTURE;
            end
            CAPTURE: begin
                w_next = RESP;
            end
            WRITE: begin
                write = 1'b1;
`ifdef RAM_SEQ_VERIFY_EN
                if (w_wr_last) w_next = VREAD;
`else
                if (w_wr_last) w_next = RESP;
`endif
            end
`ifdef RAM_SEQ_VERIFY_EN
            VREAD: begin
                read = 1'b1;
                if (w_rd_last) w_next = VCAPTURE;
            end
            VCAPTURE: begin
                w_next = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_seq.sv
// Directed bench for ram_seq with a behavioural MAR/MDR + SRAM responder.
module tb_ram_seq;

    localparam int RC = 2;
    localparam int WC = 2;
`ifdef RAM_SEQ_VERIFY_EN
    localparam int VX  = RC + 1;
    localparam int VEN = 1;
`else
    localparam int VX  = 0;
    localparam int VEN = 0;
`endif

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] reg_d;
    logic [15:0] reg_q;
    logic        reg_sel;
    logic        reg_load_ub;
    logic        reg_load_lb;
    logic        read;
    logic        write;
    logic [3:0]  dbg_state;

    ram_seq #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .reg_d(reg_d), .reg_q(reg_q), .reg_sel(reg_sel),
        .reg_load_ub(reg_load_ub), .reg_load_lb(reg_load_lb),
        .read(read), .write(write), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // register block + SRAM responder
    logic [15:0] m_mar;
    logic [15:0] m_mdr;
    logic [15:0] mem [0:255];
    logic        corrupt;

    always @(posedge clock) begin
        if (reg_sel) begin
            if (reg_load_ub) m_mar[15:8] <= reg_d[15:8];
            if (reg_load_lb) m_mar[7:0]  <= reg_d[7:0];
        end else begin
            if (reg_load_ub) m_mdr[15:8] <= reg_d[15:8];
            if (reg_load_lb) m_mdr[7:0]  <= reg_d[7:0];
        end
        if (read)  m_mdr <= mem[m_mar[7:0]] ^ {15'd0, corrupt};
        if (write) mem[m_mar[7:0]] <= m_mdr;
    end
    assign reg_q = reg_sel ? m_mar : m_mdr;

    // scoreboard
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          k, n_rd, n_wr, n_both, n_mdr;
    logic [15:0] mdr_d;
    logic [1:0]  mdr_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // driver: present a request in IDLE, hold it over the accepting edge
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic [15:0] exp_rd);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        exp_q.push_back(exp_rd);
        tick;
        req_valid = 1'b0;
        k = 1; n_rd = 0; n_wr = 0; n_both = 0; n_mdr = 0; mdr_d = 16'd0; mdr_be = 2'b00;
    endtask

    // walk the transaction until rsp_valid, tallying the command strobes
    task automatic run_to_rsp(input string tag, input int lat, input int rd, input int wr);
        logic [15:0] e;
        while (!rsp_valid && k < 64) begin
            if (read)  n_rd++;
            if (write) n_wr++;
            if (read && write) n_both++;
            if (!reg_sel && (reg_load_ub || reg_load_lb)) begin
                n_mdr++; mdr_d = reg_d; mdr_be = {reg_load_ub, reg_load_lb};
            end
            tick;
            k++;
        end
        check({tag, "_latency"}, k, lat);
        check({tag, "_read_cycles"}, n_rd, rd);
        check({tag, "_write_cycles"}, n_wr, wr);
        check({tag, "_rd_wr_overlap"}, n_both, 0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, e});
    endtask

    task automatic complete(input string tag);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0;
        req_wdata = 16'd0; req_be = 2'b00; rsp_ready = 1'b0; corrupt = 1'b0;
        tick; tick;
        // reset values
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_cmds", {27'd0, reg_sel, reg_load_ub, reg_load_lb, read, write}, 32'd0);
        check("rst_reg_d", {16'd0, reg_d}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;
        tick;

        // full-word write
        issue(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
        check("mar_sel", {31'd0, reg_sel}, 32'd1);
        check("mar_loads", {30'd0, reg_load_ub, reg_load_lb}, 32'd3);
        check("mar_reg_d", {16'd0, reg_d}, 32'h0010);
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        run_to_rsp("wr11", 5 + VX, VEN * RC, WC);
        check("wr11_mdr_loads", n_mdr, 1);
        check("wr11_mdr_d", {16'd0, mdr_d}, 32'hBEEF);
        check("wr11_mdr_be", {30'd0, mdr_be}, 32'd3);
        check("wr11_err", {31'd0, rsp_err}, 32'd0);
        complete("wr11");

        // read back
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);
        run_to_rsp("rd1", 5, RC, 0);
        check("rd1_mdr_loads", n_mdr, 0);
        complete("rd1");

        // lower-byte read-modify-write
        issue(1'b1, 16'h0010, 16'h12AA, 2'b01, 16'h0000);
        run_to_rsp("rmw01", 7 + VX, RC + VEN * RC, WC);
        check("rmw01_mdr_be", {30'd0, mdr_be}, 32'd1);
        check("rmw01_mdr_d", {16'd0, mdr_d}, 32'h12AA);
        check("rmw01_err", {31'd0, rsp_err}, 32'd0);
        complete("rmw01");
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAA);
        run_to_rsp("rd2", 5, RC, 0);
        complete("rd2");

        // upper-byte read-modify-write
        issue(1'b1, 16'h0010, 16'h55CC, 2'b10, 16'h0000);
        run_to_rsp("rmw10", 7 + VX, RC + VEN * RC, WC);
        check("rmw10_mdr_be", {30'd0, mdr_be}, 32'd2);
        complete("rmw10");
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'h55AA);
        run_to_rsp("rd3", 5, RC, 0);
        complete("rd3");

        // be=00: no SRAM traffic, response held while rsp_ready low
        issue(1'b1, 16'h0010, 16'hFFFF, 2'b00, 16'h0000);
        run_to_rsp("wr00", 2, 0, 0);
        check("wr00_mdr_loads", n_mdr, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("wr00_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("wr00_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        complete("wr00");
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'h55AA);
        run_to_rsp("rd4", 5, RC, 0);
        complete("rd4");

        // asynchronous reset in the middle of WRITE
        issue(1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000);
        tick; tick;
        check("mid_write_high", {31'd0, write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_write_drop", {31'd0, write}, 32'd0);
        check("async_ready", {31'd0, req_ready}, 32'd1);
        check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_q.delete();
        tick;
        reset_n = 1'b1;
        tick; tick;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_rst_state", {28'd0, dbg_state}, 32'd0);
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'h55AA);
        run_to_rsp("rd5", 5, RC, 0);
        complete("rd5");

        // verify read-back: corrupted then clean
        corrupt = 1'b1;
        issue(1'b1, 16'h0030, 16'hBEEF, 2'b11, 16'h0000);
        run_to_rsp("vfy_bad", 5 + VX, VEN * RC, WC);
        check("vfy_bad_err", {31'd0, rsp_err}, VEN);
        complete("vfy_bad");
        corrupt = 1'b0;
        issue(1'b1, 16'h0030, 16'hBEEF, 2'b11, 16'h0000);
        run_to_rsp("vfy_ok", 5 + VX, VEN * RC, WC);
        check("vfy_ok_err", {31'd0, rsp_err}, 32'd0);
        complete("vfy_ok");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
